// File: rtl/hc595_frame_src.sv
// hc595_frame_src: debounced key press counter with 4-digit BCD scan, one frame per slot to a 595 serializer
module hc595_frame_src #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SCAN_CYC     = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [15:0] bcd
);
  localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SW = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 1;

  typedef enum logic {IDLE, VALID} state_t;

  logic [1:0]    sync_q;
  logic          db_q, db_d, db_prev_q, press_q, db_hit;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          tick;
  logic [1:0]    idx_q, idx_d;
  state_t        state_q, state_d;
  logic [15:0]   frame_q, frame_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          carry;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // The debounced level flips only after the synced level has differed for DEBOUNCE_CYC cycles
  assign db_hit   = (sync_q[1] != db_q) && (db_cnt_q == DW'(DEBOUNCE_CYC - 1));
  assign db_cnt_d = (sync_q[1] == db_q || db_hit) ? '0 : db_cnt_q + DW'(1);
  assign db_d     = db_hit ? sync_q[1] : db_q;

  assign tick   = scan_q == SW'(SCAN_CYC - 1);
  assign scan_d = tick ? '0 : scan_q + SW'(1);

  // Decimal increment with per-digit carry; 9999 rolls over to 0000
  always_comb begin
    bcd_d = bcd_q;
    carry = press_q;
    for (int i = 0; i < 4; i++) begin
      bcd_d[4*i+:4] = carry ? ((bcd_q[4*i+:4] == 4'd9) ? 4'd0 : bcd_q[4*i+:4] + 4'd1) : bcd_q[4*i+:4];
      carry = carry & (bcd_q[4*i+:4] == 4'd9);
    end
  end

  // Frame FSM: latch on tick when idle, hold until the serializer takes it; ticks while busy are dropped
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    if (state_q == IDLE && tick) begin
      state_d = VALID;
      idx_d   = idx_q + 2'd1;
      frame_d = {seg7(bcd_q[{idx_q, 2'b00}+:4]), 4'b0000, 4'b0001 << idx_q};
    end else if (state_q == VALID && frame_ready) begin
      state_d = IDLE;
    end
  end

  // Key synchronizer and registered press pulse on the debounced falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      db_prev_q <= 1'b1;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key};
      db_prev_q <= db_q;
      press_q   <= db_prev_q & ~db_q;
    end
  end

  // Debounce, scan timer, press counter and frame state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q     <= 1'b1;
      db_cnt_q <= '0;
      scan_q   <= '0;
      bcd_q    <= 16'h0000;
      idx_q    <= 2'd0;
      state_q  <= IDLE;
      frame_q  <= 16'hFF00;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      scan_q   <= scan_d;
      bcd_q    <= bcd_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      frame_q  <= frame_d;
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = state_q == VALID;
  assign bcd         = bcd_q;
endmodule

// File: tb/tb_hc595_frame_src.sv
// tb_hc595_frame_src: directed vector table plus hand sequences for bounce, stall, reset and rollover
module tb_hc595_frame_src;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key = 1'b1;
  logic        frame_ready = 1'b1;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic [15:0] bcd;

  int vecs = 0;
  int fails = 0;
  int ecnt = 0;
  int hs = 0;

  typedef struct {
    int          e;
    logic        k;
    logic        r;
    logic        cd;
    logic        v;
    logic [15:0] d;
    logic [15:0] b;
  } vec_t;

  localparam int NA = 16;
  vec_t tv[NA];

  hc595_frame_src #(.DEBOUNCE_CYC(8), .SCAN_CYC(16)) dut (
    .clk(clk), .rst(rst), .key(key),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .bcd(bcd)
  );

  always #5 clk = ~clk;

  // Edge count since reset release and count of completed handshakes
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecnt <= 0;
      hs   <= 0;
    end else begin
      ecnt <= ecnt + 1;
      if (frame_valid && frame_ready) hs <= hs + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] segx(input logic [3:0] d);
    logic [7:0] t [10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  function automatic logic [15:0] exp_frame(input int n, input logic [15:0] b);
    logic [1:0] i;
    logic [3:0] s;
    i = 2'(n % 4);
    s = 4'b0001 << i;
    return {segx(b[{i, 2'b00}+:4]), 4'b0000, s};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, ecnt, act, exp);
    end
  endtask

  task automatic step_to(input int k);
    while (ecnt < k) @(negedge clk);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !frame_valid; i++) @(negedge clk);
    chk("wait_valid", {31'd0, frame_valid}, 32'd1);
  endtask

  initial begin
    logic [15:0] d0;
    int e1;
    tv[0]  = '{0,   1'b1, 1'b1, 1'b1, 1'b0, 16'hFF00, 16'h0000};
    tv[1]  = '{15,  1'b1, 1'b1, 1'b1, 1'b0, 16'hFF00, 16'h0000};
    tv[2]  = '{16,  1'b1, 1'b1, 1'b1, 1'b1, 16'hC001, 16'h0000};
    tv[3]  = '{17,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[4]  = '{32,  1'b1, 1'b1, 1'b1, 1'b1, 16'hC002, 16'h0000};
    tv[5]  = '{48,  1'b1, 1'b1, 1'b1, 1'b1, 16'hC004, 16'h0000};
    tv[6]  = '{64,  1'b1, 1'b1, 1'b1, 1'b1, 16'hC008, 16'h0000};
    tv[7]  = '{80,  1'b1, 1'b1, 1'b1, 1'b1, 16'hC001, 16'h0000};
    tv[8]  = '{81,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[9]  = '{92,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tv[10] = '{93,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001};
    tv[11] = '{96,  1'b0, 1'b1, 1'b1, 1'b1, 16'hC002, 16'h0001};
    tv[12] = '{112, 1'b0, 1'b1, 1'b1, 1'b1, 16'hC004, 16'h0001};
    tv[13] = '{121, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001};
    tv[14] = '{128, 1'b1, 1'b1, 1'b1, 1'b1, 16'hC008, 16'h0001};
    tv[15] = '{144, 1'b1, 1'b1, 1'b1, 1'b1, 16'hF901, 16'h0001};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NA; i++) begin
      step_to(tv[i].e);
      chk("valid", {31'd0, frame_valid}, {31'd0, tv[i].v});
      if (tv[i].cd) chk("data", {16'd0, frame_data}, {16'd0, tv[i].d});
      chk("bcd", {16'd0, bcd}, {16'd0, tv[i].b});
      key = tv[i].k;
      frame_ready = tv[i].r;
    end
    step_to(150);
    chk("release_noop", {16'd0, bcd}, 32'h0001);

    // bounce: short lows never register, a steady low registers once
    for (int n = 0; n < 4; n++) begin
      key = 1'b0;
      repeat (5) @(negedge clk);
      key = 1'b1;
      repeat (3) @(negedge clk);
      chk("bounce", {16'd0, bcd}, 32'h0001);
    end
    key = 1'b0;
    e1 = ecnt + 1;
    step_to(e1 + 10);
    chk("steady_pre", {16'd0, bcd}, 32'h0001);
    step_to(e1 + 11);
    chk("steady_inc", {16'd0, bcd}, 32'h0002);
    step_to(e1 + 14);
    key = 1'b1;
    repeat (20) @(negedge clk);
    chk("steady_once", {16'd0, bcd}, 32'h0002);

    // stall: frame held constant, dropped ticks do not skip a digit
    frame_ready = 1'b0;
    wait_valid();
    d0 = frame_data;
    chk("stall_first", {16'd0, d0}, {16'd0, exp_frame(hs, 16'h0002)});
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      chk("stall_hold", {15'd0, frame_valid, frame_data}, {15'd0, 1'b1, d0});
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("stall_drop", {31'd0, frame_valid}, 32'd0);
    wait_valid();
    chk("stall_next", {16'd0, frame_data}, {16'd0, exp_frame(hs, 16'h0002)});

    // asynchronous reset in the middle of a pending frame
    #2;
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_data", {16'd0, frame_data}, 32'hFF00);
    chk("rst_bcd", {16'd0, bcd}, 32'h0000);
    @(negedge clk);
    rst = 1'b1;
    frame_ready = 1'b1;
    step_to(15);
    chk("rst_e15", {31'd0, frame_valid}, 32'd0);
    step_to(16);
    chk("rst_e16", {15'd0, frame_valid, frame_data}, {15'd0, 1'b1, 16'hC001});
    step_to(32);
    chk("rst_e32", {15'd0, frame_valid, frame_data}, {15'd0, 1'b1, 16'hC002});

    // preset to 9999, one press rolls over to 0000
    step_to(33);
    force dut.bcd_q = 16'h9999;
    step_to(34);
    release dut.bcd_q;
    chk("preset", {16'd0, bcd}, 32'h9999);
    step_to(35);
    key = 1'b0;
    step_to(46);
    chk("wrap_pre", {16'd0, bcd}, 32'h9999);
    step_to(47);
    chk("wrap", {16'd0, bcd}, 32'h0000);
    step_to(48);
    chk("wrap_f48", {15'd0, frame_valid, frame_data}, {15'd0, 1'b1, 16'hC004});
    step_to(60);
    key = 1'b1;
    step_to(64);
    chk("wrap_f64", {15'd0, frame_valid, frame_data}, {15'd0, 1'b1, 16'hC008});
    step_to(80);
    chk("wrap_f80", {15'd0, frame_valid, frame_data}, {15'd0, 1'b1, 16'hC001});
    step_to(96);
    chk("wrap_f96", {15'd0, frame_valid, frame_data}, {15'd0, 1'b1, 16'hC002});
    chk("wrap_hold", {16'd0, bcd}, 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
